sha256_compress: RTL
====================

# sha256_compress

Iterative SHA-256 compression core: it runs the 64 rounds for one 512-bit message block, one round per clock, from the chaining value supplied on `h_in`. It sits directly upstream of the per-word hash-state registers (H0..H7). Those registers add the final working variables `a_out`..`h_out` into their own value on the `done` pulse. The core owns its message schedule internally, so the only per-block inputs are the block and the chaining value.

## Interface
- No parameters (SHA-256 widths and round count are fixed).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request to compress one block; honoured only when `busy`=0.
- `block_in` in 512: message block; W0 = [511:480] … W15 = [31:0], big-endian words.
- `h_in` in 256: chaining value; H0 = [255:224] … H7 = [31:0].
- `busy` out 1: high while rounds are in progress.
- `done` out 1: one-cycle pulse when the final working variables are valid.
- `a_out`..`h_out` out 32 each: working variables a..h.

## Operation
- States:
  - IDLE: accepts `start`.
  - RUN: rounds t=0..63.
  - DONE: one cycle, `done`=1.
- IDLE→RUN on `start`:
  - a..h are loaded from H0..H7 of `h_in`.
  - The 16-word schedule window is loaded from `block_in`.
  - t=0; `busy`=1.
- RUN, every cycle:
  - W_t = window[0].
  - T1 = h + Σ1(e) + Ch(e,f,g) + K_t + W_t.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - The window shifts down one word; the new window[15] = σ1(w[14]) + w[9] + σ0(w[1]) + w[0].
  - t increments.
- All additions are modulo 2^32; carries are discarded.
- The round at t=63 moves the core to DONE and drops `busy`.
- DONE→IDLE unconditionally after one cycle.
- `start` while `busy`=1 is ignored; there is no queueing and no error flag.
- `start` during the DONE cycle is accepted: the core goes straight to RUN with the new operands.
- `a_out`..`h_out` are the working registers themselves:
  - They change every cycle during RUN.
  - They are valid when `done`=1 and hold that value through IDLE until the next accepted `start`.
- `block_in` and `h_in` are sampled only on the accepting edge; the core ignores later changes.

## Timing
- Reset values: `busy`=0, `done`=0, `a_out`..`h_out`=0, state=IDLE, t=0, schedule window=0.
- Reset asserted mid-RUN aborts the block immediately. No `done` is produced for the aborted block.
- `start` sampled high at edge N (IDLE):
  - Round t is applied at edge N+1+t.
  - At edge N+64 the last round is applied, `busy` falls and `done` rises.
  - At edge N+65 `done` falls.
- Back-to-back blocks: the next `start` can be accepted at edge N+65. Throughput is 1 block per 65 cycles.
- `busy` rises on the edge that accepts `start`. It is never high in the same cycle as `done`.
- Combinational path per cycle is one T1+T2 adder chain (roughly 7 operands into `a`). No multi-cycle paths.

## Structure
- Shared package `sha256_pkg` holds:
  - K[0:63] round-constant table.
  - IV H0..H7 (0x6a09e667 … 0x5be0cd19).
  - Functions Σ0, Σ1, σ0, σ1, Ch, Maj.
  - State enum IDLE/RUN/DONE.
  - The 6-bit round-counter type.
- Sub-module `sha256_msg_sched`:
  - 16×32 shift window with load, shift-enable and W_t output.
  - Uses the same `clk`/`rst_n`.
- The top holds the FSM, the round counter, the a..h registers and the round datapath.

## Test plan
- "abc" vector: `h_in` = IV, `block_in` = 0x61626380 followed by zeros, last word 0x00000018, `start` pulse. Required:
  - After the edge N+1: a=0x5d6aebcd, e=0xfa2a4622.
  - At `done`: a=0x506e3058, e=0x5ef50f24, g=0x948d25b6, h=0x961f4894.
  - `done` high exactly one cycle, 64 edges after acceptance.
- Second `start` pulse while `busy` (e.g. at round 20) → ignored; results identical to the undisturbed "abc" run; exactly one `done`.
- Back-to-back: "abc" block accepted, then `start` held high through DONE with a new block → second block accepted at edge N+65. Both `done` pulses carry correct values; `busy` gap is exactly the one DONE cycle.
- `rst_n` pulled low at round 30 → all outputs 0 asynchronously, no `done`. A fresh "abc" run afterwards gives the reference values.
- Operand stability: change `block_in` and `h_in` to all-ones the cycle after acceptance → results unchanged from the "abc" reference.
- Wrap-around: `h_in` = all 0xffffffff, `block_in` = all ones → output matches a software SHA-256 model of this block; checks modulo-2^32 carry discard.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, round functions, FSM state and round-counter types.
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [5:0] round_t;
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word rolling message-schedule window; w is the current round's W_t.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block,
  output logic [31:0]  w
);
  logic [31:0] win [16];
  logic [31:0] nxt;
  assign w = win[0];
  assign nxt = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= nxt;
    end
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: iterative SHA-256 compression, one round per clock over a single 512-bit block.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] h_in,
  output logic         busy,
  output logic         done,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out,
  output logic [31:0]  e_out,
  output logic [31:0]  f_out,
  output logic [31:0]  g_out,
  output logic [31:0]  h_out
);
  state_t state;
  round_t t;
  logic [31:0] w, t1, t2;
  logic accept;
  // DONE also accepts so back-to-back blocks cost only the single DONE cycle
  assign accept = start && state != RUN;
  assign t1 = h_out + bsig1(e_out) + ch(e_out, f_out, g_out) + K[t] + w;
  assign t2 = bsig0(a_out) + maj(a_out, b_out, c_out);
  sha256_msg_sched u_sched (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .shift(state == RUN),
    .block(block_in),
    .w(w)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      t <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out} <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state <= RUN;
        t <= '0;
        busy <= 1'b1;
        {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out} <= h_in;
      end else if (state == RUN) begin
        {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out} <=
          {t1 + t2, a_out, b_out, c_out, d_out + t1, e_out, f_out, g_out};
        t <= t + 6'd1;
        if (t == 6'd63) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
endmodule
